// File: rtl/uart_imem_loader_if.sv
// rtl/uart_imem_loader_if.sv - UART byte input and instruction-memory write bus for the loader
// slave is the loader side; master is the receiver/memory environment.
interface uart_imem_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_break;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport slave (
    input  rx_valid,
    input  rx_data,
    input  rx_break,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport master (
    output rx_valid,
    output rx_data,
    output rx_break,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/uart_imem_loader.sv
// rtl/uart_imem_loader.sv - assembles UART bytes LSB-first into 32-bit words and writes them to IMEM
// Optional partial-word idle timeout: define LOADER_TIMEOUT_EN.
module uart_imem_loader #(
  parameter int          ADDR_W         = 8,
  parameter logic [31:0] END_WORD       = 32'hFFFF_FFFF,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  uart_imem_loader_if.slave   bus,
  output logic                write_done,
  output logic                overflow,
  output logic [ADDR_W:0]     word_count
);

  typedef enum logic {LOAD, DONE} state_t;

  state_t            state_q;
  logic [1:0]        byte_idx_q;
  logic [23:0]       lanes_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              done_q;
  logic              ovf_q;
  logic [ADDR_W:0]   count_q;

  logic              tmo_hit;
  logic [1:0]        idx_d;
  logic [31:0]       word_d;

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;

  assign tmo_hit = (byte_idx_q != 2'd0) && (tmo_q == TW'(TIMEOUT_CYCLES));

  // Idle counter only runs while a word is partially assembled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (state_q != LOAD || byte_idx_q == 2'd0 || bus.rx_break ||
                 bus.rx_valid || tmo_hit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  // A byte arriving on the expiry cycle starts a fresh word rather than extending the stale one.
  assign idx_d  = tmo_hit ? 2'd0 : byte_idx_q;
  assign word_d = {bus.rx_data, lanes_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD;
      byte_idx_q <= 2'd0;
      lanes_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (bus.rx_break) begin
            byte_idx_q <= 2'd0;
          end else if (bus.rx_valid) begin
            case (idx_d)
              2'd0: begin
                lanes_q[7:0] <= bus.rx_data;
                byte_idx_q   <= 2'd1;
              end
              2'd1: begin
                lanes_q[15:8] <= bus.rx_data;
                byte_idx_q    <= 2'd2;
              end
              2'd2: begin
                lanes_q[23:16] <= bus.rx_data;
                byte_idx_q     <= 2'd3;
              end
              default: begin
                byte_idx_q <= 2'd0;
                if (word_d == END_WORD) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
                end else if (count_q[ADDR_W]) begin
                  ovf_q   <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= DONE;
                end else begin
                  we_q    <= 1'b1;
                  addr_q  <= count_q[ADDR_W-1:0];
                  wdata_q <= word_d;
                  count_q <= count_q + 1'b1;
                end
              end
            endcase
          end else if (tmo_hit) begin
            byte_idx_q <= 2'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign write_done     = done_q;
  assign overflow       = ovf_q;
  assign word_count     = count_q;

endmodule

// File: doc/uart_imem_loader.md
# uart_imem_loader

Byte-to-word assembler between the UART receiver and the instruction memory of the RISC-V wrapper. It collects received bytes least-significant first into 32-bit instruction words and writes each word to consecutive instruction-memory addresses. An all-ones word ends the load and raises `write_done`, which releases the core from program-load mode.

## Interface

Parameters:
- `ADDR_W`, 8: instruction-memory word-address width; capacity is 2^ADDR_W words.
- `END_WORD`, 32'hFFFF_FFFF: terminator word; ends the load and is never written.
- `TIMEOUT_CYCLES`, 1_000_000: maximum idle gap between bytes of one word. Used only with `LOADER_TIMEOUT_EN`.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `rx_valid`, in, 1: one-cycle pulse; `rx_data` holds a received byte.
- `rx_data`, in, 8: received byte.
- `rx_break`, in, 1: UART BREAK detected; level or pulse.
- `imem_we`, out, 1: one-cycle write strobe.
- `imem_addr`, out, ADDR_W: word address of the current write.
- `imem_wdata`, out, 32: assembled instruction word.
- `write_done`, out, 1: sticky; high once the load has finished.
- `overflow`, out, 1: sticky; a word arrived after memory was full.
- `word_count`, out, ADDR_W+1: number of words written so far.

## Operation

- State machine with two states, LOAD and DONE. Reset enters LOAD.
- LOAD:
  - Each `rx_valid` shifts the byte into lane `byte_idx` of the word: lane 0 is bits [7:0], lane 3 is bits [31:24].
  - `byte_idx` is 2 bits and increments per byte.
  - When the 4th byte arrives (`byte_idx` = 3), the word is complete and `byte_idx` wraps to 0.
- Complete word equals `END_WORD`:
  - No write occurs.
  - `write_done` is set and the FSM moves to DONE.
- Complete word is any other value, with `word_count` < 2^ADDR_W:
  - `imem_we` pulses with `imem_addr` = `word_count[ADDR_W-1:0]` and `imem_wdata` = the word.
  - `word_count` then increments.
- Complete word is any other value, with `word_count` = 2^ADDR_W (memory full):
  - No write occurs.
  - `overflow` and `write_done` are both set and the FSM moves to DONE.
- `rx_break` in LOAD discards the partial word: `byte_idx` returns to 0 and `word_count` is unchanged.
- If `rx_break` and `rx_valid` occur in the same cycle, break wins and the byte is dropped.
- DONE: all `rx_valid` and `rx_break` are ignored. Only `rst` leaves DONE.
- Reset mid-word or mid-load:
  - The partial word is lost and nothing is written.
  - `byte_idx`, `word_count`, `write_done` and `overflow` all clear.

## Timing

- Reset values:
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `write_done`=0, `overflow`=0, `word_count`=0.
- All outputs are registered.
- 4th byte `rx_valid` in cycle N:
  - `imem_we`=1 for exactly cycle N+1.
  - `imem_addr` and `imem_wdata` are valid in cycle N+1 and hold until the next write.
  - `word_count` shows its new value in cycle N+1.
- Terminator completes in cycle N: `write_done` is high from N+1.
- `overflow` also rises in N+1 when it applies.
- Throughput: a byte may be accepted every cycle. An `rx_valid` in cycle N+1 during the write strobe is captured normally, because capture and write paths are independent.
- No backpressure: the instruction memory must accept a write every cycle.

## Configuration

- `LOADER_TIMEOUT_EN` defined:
  - A counter runs in LOAD while `byte_idx` ≠ 0. It resets on every accepted byte.
  - When it reaches `TIMEOUT_CYCLES`, the partial word is discarded (`byte_idx` returns to 0) on the following edge. No write occurs.
  - This keeps the loader aligned after a dropped byte.
- `LOADER_TIMEOUT_EN` undefined:
  - No counter is built.
  - A partial word waits indefinitely; only `rx_break` or `rst` clears it.

## Test plan

- Bytes 13,01,01,FC → one `imem_we` pulse with addr 0, data 32'hFC010113; `word_count`=1.
- Words 32'h00000013 then 32'hFFFFFFFF → one write at addr 0; `write_done`=1 one cycle after the last FF byte; bytes sent afterwards cause no writes.
- Bytes 13,01, then `rx_break`, then 93,07,10,00 → single write of 32'h00100793 at addr 0.
- `ADDR_W`=2: write 4 words, then send a 5th non-terminator word → no 5th write; `overflow`=1, `write_done`=1, `word_count`=4.
- Assert `rst` after 3 bytes, then send 4 new bytes → first write at addr 0 containing only the new bytes.
- With `LOADER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100: send 2 bytes, wait 150 cycles, send 4 bytes → exactly one write, containing the last 4 bytes.
